// File: rtl/freelist_pkg.sv
// Shared sizing, pointer type and pointer arithmetic for the physical-register free list.
package freelist_pkg;

  localparam int PREG_NUM    = 64;
  localparam int AREG_NUM    = 32;
  localparam int FL_SIZE     = PREG_NUM - AREG_NUM;
  localparam int FL_SIZE_LOG = $clog2(FL_SIZE);
  localparam int PREG_W      = $clog2(PREG_NUM);

  typedef logic [PREG_W-1:0] preg_t;

  // Same flag+idx convention as the ROB: flag toggles every time idx wraps.
  typedef struct packed {
    logic                   flag;
    logic [FL_SIZE_LOG-1:0] idx;
  } fl_ptr_t;

  // Advancing the packed {flag, idx} as one number wraps idx and toggles flag together.
  function automatic fl_ptr_t fl_ptr_add(fl_ptr_t p, logic [1:0] n);
    logic [FL_SIZE_LOG:0] sum;
    sum = {p.flag, p.idx} + {{(FL_SIZE_LOG-1){1'b0}}, n};
    return fl_ptr_t'(sum);
  endfunction

  function automatic logic [FL_SIZE_LOG:0] fl_ptr_dist(fl_ptr_t hi, fl_ptr_t lo);
    return {hi.flag, hi.idx} - {lo.flag, lo.idx};
  endfunction

endpackage

// File: rtl/freelist.sv
// Circular free list of physical registers: 2-wide allocate to rename, 2-wide compacted
// release from commit, and a committed head so a redirect recovers all in-flight allocations.
module freelist
  import freelist_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   alloc0_req,
  input  logic                   alloc1_req,
  output logic                   alloc_ready,
  output logic [PREG_W-1:0]      alloc0_prd,
  output logic [PREG_W-1:0]      alloc1_prd,
  input  logic                   commit0_valid,
  input  logic                   commit0_need_free,
  input  logic [PREG_W-1:0]      commit0_old_prd,
  input  logic                   commit1_valid,
  input  logic                   commit1_need_free,
  input  logic [PREG_W-1:0]      commit1_old_prd,
  input  logic                   redirect_valid,
  output logic [FL_SIZE_LOG:0]   free_count
);

  fl_ptr_t spec_head_q, spec_head_d;
  fl_ptr_t arch_head_q, arch_head_d;
  fl_ptr_t tail_q,      tail_d;

  preg_t entry_q  [FL_SIZE];
  preg_t entry_d  [FL_SIZE];
  logic  entry_we [FL_SIZE];

  logic                   r0, r1;
  logic                   alloc_fire;
  logic [1:0]             alloc_num;
  logic [1:0]             rel_num;
  logic [FL_SIZE_LOG-1:0] rd1_idx;
  logic [FL_SIZE_LOG-1:0] wr0_idx;
  logic [FL_SIZE_LOG-1:0] wr1_idx;

  // Status and read ports look only at registered state.
  always_comb begin
    free_count  = fl_ptr_dist(tail_q, spec_head_q);
    alloc_ready = (free_count >= (FL_SIZE_LOG+1)'(2));
    rd1_idx     = spec_head_q.idx + {{(FL_SIZE_LOG-1){1'b0}}, alloc0_req};
    alloc0_prd  = entry_q[spec_head_q.idx];
    alloc1_prd  = entry_q[rd1_idx];
  end

  always_comb begin
    r0         = commit0_valid & commit0_need_free;
    r1         = commit1_valid & commit1_need_free;
    rel_num    = {1'b0, r0} + {1'b0, r1};
    alloc_num  = {1'b0, alloc0_req} + {1'b0, alloc1_req};
    alloc_fire = alloc_ready & ~redirect_valid;
    wr0_idx    = tail_q.idx;
    wr1_idx    = tail_q.idx + {{(FL_SIZE_LOG-1){1'b0}}, r0};
  end

  // Release writes are compacted: commit1 slides into slot 0 when commit0 frees nothing.
  always_comb begin
    for (int i = 0; i < FL_SIZE; i++) begin
      entry_we[i] = 1'b0;
      entry_d[i]  = entry_q[i];
      if (r0 && (wr0_idx == FL_SIZE_LOG'(i))) begin
        entry_we[i] = 1'b1;
        entry_d[i]  = commit0_old_prd;
      end
      if (r1 && (wr1_idx == FL_SIZE_LOG'(i))) begin
        entry_we[i] = 1'b1;
        entry_d[i]  = commit1_old_prd;
      end
    end
  end

  always_comb begin
    tail_d      = fl_ptr_add(tail_q, rel_num);
    arch_head_d = fl_ptr_add(arch_head_q, rel_num);
    spec_head_d = spec_head_q;
    if (redirect_valid) begin
      spec_head_d = arch_head_d;
    end else if (alloc_fire) begin
      spec_head_d = fl_ptr_add(spec_head_q, alloc_num);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      spec_head_q <= '0;
      arch_head_q <= '0;
      tail_q      <= '{flag: 1'b1, idx: '0};
    end else begin
      spec_head_q <= spec_head_d;
      arch_head_q <= arch_head_d;
      tail_q      <= tail_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FL_SIZE; i++) begin
        entry_q[i] <= preg_t'(AREG_NUM + i);
      end
    end else begin
      for (int i = 0; i < FL_SIZE; i++) begin
        if (entry_we[i]) begin
          entry_q[i] <= entry_d[i];
        end
      end
    end
  end

  logic [FL_SIZE_LOG+1:0] fill_after_rel;
  assign fill_after_rel = {1'b0, free_count} + {{FL_SIZE_LOG{1'b0}}, rel_num};

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    fill_after_rel <= (FL_SIZE_LOG+2)'(FL_SIZE));

  a_arch_behind_spec: assert property (@(posedge clock) disable iff (!reset_n)
    fl_ptr_dist(spec_head_q, arch_head_q) >= {{(FL_SIZE_LOG-1){1'b0}}, rel_num});

  a_commit_order: assert property (@(posedge clock) disable iff (!reset_n)
    commit1_valid |-> commit0_valid);

endmodule

// File: tb/tb_freelist.sv
// Scoreboard bench for freelist: an ordered-queue model of free and in-flight pregs.
module tb_freelist;
  import freelist_pkg::*;

  logic                 clock;
  logic                 reset_n;
  logic                 alloc0_req, alloc1_req;
  logic                 alloc_ready;
  logic [PREG_W-1:0]    alloc0_prd, alloc1_prd;
  logic                 commit0_valid, commit0_need_free;
  logic [PREG_W-1:0]    commit0_old_prd;
  logic                 commit1_valid, commit1_need_free;
  logic [PREG_W-1:0]    commit1_old_prd;
  logic                 redirect_valid;
  logic [FL_SIZE_LOG:0] free_count;

  freelist dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .alloc0_req        (alloc0_req),
    .alloc1_req        (alloc1_req),
    .alloc_ready       (alloc_ready),
    .alloc0_prd        (alloc0_prd),
    .alloc1_prd        (alloc1_prd),
    .commit0_valid     (commit0_valid),
    .commit0_need_free (commit0_need_free),
    .commit0_old_prd   (commit0_old_prd),
    .commit1_valid     (commit1_valid),
    .commit1_need_free (commit1_need_free),
    .commit1_old_prd   (commit1_old_prd),
    .redirect_valid    (redirect_valid),
    .free_count        (free_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_t;

  int  fl_q[$];
  int  inflight_q[$];
  sb_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] observe(input string tag);
    if (tag == "free_count")  return 32'(free_count);
    if (tag == "alloc_ready") return 32'(alloc_ready);
    if (tag == "alloc0_prd")  return 32'(alloc0_prd);
    return 32'(alloc1_prd);
  endfunction

  task automatic model_reset();
    fl_q.delete();
    inflight_q.delete();
    for (int i = 0; i < FL_SIZE; i++) fl_q.push_back(AREG_NUM + i);
  endtask

  task automatic push_exp(input string tag, input int val);
    sb_t e;
    e.tag = tag;
    e.val = 32'(val);
    exp_q.push_back(e);
  endtask

  task automatic drive_cycle(input logic a0, input logic a1,
                             input logic c0v, input logic c0n, input logic [PREG_W-1:0] c0p,
                             input logic c1v, input logic c1n, input logic [PREG_W-1:0] c1p,
                             input logic rd);
    bit fire;
    int a0i;
    @(negedge clock);
    alloc0_req = a0;  alloc1_req = a1;
    commit0_valid = c0v;  commit0_need_free = c0n;  commit0_old_prd = c0p;
    commit1_valid = c1v;  commit1_need_free = c1n;  commit1_old_prd = c1p;
    redirect_valid = rd;
    a0i = a0 ? 1 : 0;
    push_exp("free_count", fl_q.size());
    push_exp("alloc_ready", (fl_q.size() >= 2) ? 1 : 0);
    if (fl_q.size() > 0)   push_exp("alloc0_prd", fl_q[0]);
    if (fl_q.size() > a0i) push_exp("alloc1_prd", fl_q[a0i]);
    #1;
    while (exp_q.size() > 0) begin
      sb_t e;
      e = exp_q.pop_front();
      chk(e.tag, observe(e.tag), e.val);
    end
    fire = (fl_q.size() >= 2) && !rd;
    if (c0v && c0n) begin
      void'(inflight_q.pop_front());
      fl_q.push_back(int'(c0p));
    end
    if (c1v && c1n) begin
      void'(inflight_q.pop_front());
      fl_q.push_back(int'(c1p));
    end
    if (fire && a0) inflight_q.push_back(fl_q.pop_front());
    if (fire && a1) inflight_q.push_back(fl_q.pop_front());
    if (rd) begin
      for (int i = inflight_q.size() - 1; i >= 0; i--) fl_q.push_front(inflight_q[i]);
      inflight_q.delete();
    end
    @(posedge clock);
  endtask

  task automatic idle_cycle();
    drive_cycle(0, 0, 0, 0, '0, 0, 0, '0, 0);
  endtask

  // Reset asserted mid-cycle, away from any clock edge, then released on a falling edge.
  task automatic async_reset();
    @(negedge clock);
    alloc0_req = 0; alloc1_req = 0; commit0_valid = 0; commit0_need_free = 0;
    commit1_valid = 0; commit1_need_free = 0; redirect_valid = 0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_free_count", 32'(free_count), 32'(FL_SIZE));
    chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
    chk("rst_alloc0_prd", 32'(alloc0_prd), 32'(AREG_NUM));
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    alloc0_req = 0; alloc1_req = 0;
    commit0_valid = 0; commit0_need_free = 0; commit0_old_prd = '0;
    commit1_valid = 0; commit1_need_free = 0; commit1_old_prd = '0;
    redirect_valid = 0;
    model_reset();
    repeat (2) @(negedge clock);
    chk("reset_free_count", 32'(free_count), 32'd32);
    chk("reset_alloc_ready", 32'(alloc_ready), 32'd1);
    reset_n = 1'b1;

    idle_cycle();
    repeat (15) drive_cycle(1, 1, 0, 0, '0, 0, 0, '0, 0);
    drive_cycle(1, 1, 0, 0, '0, 0, 0, '0, 0);
    drive_cycle(1, 1, 0, 0, '0, 0, 0, '0, 0);
    idle_cycle();

    drive_cycle(0, 0, 1, 1, 6'd5, 1, 1, 6'd7, 0);
    drive_cycle(1, 1, 0, 0, '0, 0, 0, '0, 0);
    idle_cycle();

    async_reset();
    drive_cycle(0, 1, 0, 0, '0, 0, 0, '0, 0);
    repeat (3) drive_cycle(1, 1, 0, 0, '0, 0, 0, '0, 0);
    drive_cycle(0, 0, 1, 1, 6'd3, 1, 1, 6'd4, 0);
    drive_cycle(0, 0, 0, 0, '0, 0, 0, '0, 1);
    idle_cycle();

    drive_cycle(1, 1, 0, 0, '0, 0, 0, '0, 0);
    drive_cycle(1, 1, 1, 0, '0, 1, 1, 6'd9, 1);
    idle_cycle();

    for (int k = 0; k < 400; k++) begin
      logic a0, a1, c0v, c0n, c1v, c1n, rd;
      logic [PREG_W-1:0] p0, p1;
      int avail;
      avail = inflight_q.size();
      a0  = ($urandom_range(0, 3) != 0);
      a1  = ($urandom_range(0, 3) != 0);
      c0v = ($urandom_range(0, 1) == 1);
      c0n = c0v && (avail >= 1) && ($urandom_range(0, 3) != 0);
      c1v = c0v && ($urandom_range(0, 1) == 1);
      c1n = c1v && (avail >= (c0n ? 2 : 1)) && ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 11) == 0);
      p0  = PREG_W'($urandom_range(0, PREG_NUM - 1));
      p1  = PREG_W'($urandom_range(0, PREG_NUM - 1));
      drive_cycle(a0, a1, c0v, c0n, p0, c1v, c1n, p1, rd);
    end

    async_reset();
    idle_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
